// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block.
package pwm_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } pwm_state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer for the PWM input plus registered rise/fall detection.
// level, rise and fall are aligned: rise/fall are high in the first cycle of the new level.
module pwm_edge_sync
  import pwm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   synced;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};
    synced = sync_q[SYNC_STAGES-1];
    dly_d  = synced;
    rise_d = synced & ~dly_q;
    fall_d = ~synced & dly_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = dly_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time capture. Optional stuck-input timeout via PWM_CAPTURE_TIMEOUT_EN.
//   state      | meaning
//   ST_IDLE    | waiting for the first rise; no reference edge yet
//   ST_MEASURE | counting since the last rise; each rise publishes a measurement
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pwmIn,
  output logic [DATA_WIDTH-1:0] measPeriod,
  output logic [DATA_WIDTH-1:0] measHigh,
  output logic                  measValid,
  output logic                  stuck,
  output logic                  stuckLevel
);

  localparam logic [DATA_WIDTH-1:0] CNT_MAX = '1;

  logic level, rise, fall;

  pwm_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] period_cnt_q, period_cnt_d;
  logic [DATA_WIDTH-1:0] high_cnt_q, high_cnt_d;
  logic                  high_run_q, high_run_d;
  logic [DATA_WIDTH-1:0] meas_period_q, meas_period_d;
  logic [DATA_WIDTH-1:0] meas_high_q, meas_high_d;
  logic                  meas_valid_q, meas_valid_d;

`ifdef PWM_CAPTURE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             stuck_q, stuck_d;
  logic             stuck_level_q, stuck_level_d;
`endif

  pwm_edge_sync u_edge_sync (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwmIn),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  always_comb begin
    state_d       = state_q;
    meas_period_d = meas_period_q;
    meas_high_d   = meas_high_q;
    meas_valid_d  = 1'b0;

    if (rise)                         period_cnt_d = DATA_WIDTH'(1);
    else if (period_cnt_q != CNT_MAX) period_cnt_d = period_cnt_q + DATA_WIDTH'(1);
    else                              period_cnt_d = period_cnt_q;

    // High time only accumulates until the first fall after the rise.
    if (rise)      high_run_d = 1'b1;
    else if (fall) high_run_d = 1'b0;
    else           high_run_d = high_run_q;

    if (rise)
      high_cnt_d = DATA_WIDTH'(1);
    else if (level && high_run_q && high_cnt_q != CNT_MAX)
      high_cnt_d = high_cnt_q + DATA_WIDTH'(1);
    else
      high_cnt_d = high_cnt_q;

    if (rise) begin
      state_d = ST_MEASURE;
      if (state_q == ST_MEASURE) begin
        meas_period_d = period_cnt_q;
        meas_high_d   = high_cnt_q;
        meas_valid_d  = 1'b1;
      end
    end

`ifdef PWM_CAPTURE_TIMEOUT_EN
    stuck_d       = 1'b0;
    stuck_level_d = stuck_level_q;
    // A rise in the same cycle as expiry takes priority and restarts the timer.
    if (rise || state_q != ST_MEASURE) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q == TMO_LAST) begin
      tmo_cnt_d     = '0;
      stuck_d       = 1'b1;
      stuck_level_d = level;
      state_d       = ST_IDLE;
    end else begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      period_cnt_q  <= '0;
      high_cnt_q    <= '0;
      high_run_q    <= 1'b0;
      meas_period_q <= '0;
      meas_high_q   <= '0;
      meas_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      period_cnt_q  <= period_cnt_d;
      high_cnt_q    <= high_cnt_d;
      high_run_q    <= high_run_d;
      meas_period_q <= meas_period_d;
      meas_high_q   <= meas_high_d;
      meas_valid_q  <= meas_valid_d;
    end
  end

`ifdef PWM_CAPTURE_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q     <= '0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      stuck_q       <= stuck_d;
      stuck_level_q <= stuck_level_d;
    end
  end

  assign stuck      = stuck_q;
  assign stuckLevel = stuck_level_q;
`else
  assign stuck      = 1'b0;
  assign stuckLevel = 1'b0;
`endif

  assign measPeriod = meas_period_q;
  assign measHigh   = meas_high_q;
  assign measValid  = meas_valid_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a 32-bit instance and a 4-bit instance share one PWM stimulus.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pwmIn = 1'b0;

  logic [31:0] measPeriod, measHigh;
  logic        measValid, stuck, stuckLevel;
  logic [3:0]  p4, h4;
  logic        v4, s4, sl4;

  int tests = 0;
  int fails = 0;
  int viol  = 0;

  int v_idx[$], v_per[$], v_high[$];
  int w_per[$], w_high[$];
  int s_idx[$];

  pwm_capture dut (
    .clk        (clk),
    .rst        (rst),
    .pwmIn      (pwmIn),
    .measPeriod (measPeriod),
    .measHigh   (measHigh),
    .measValid  (measValid),
    .stuck      (stuck),
    .stuckLevel (stuckLevel)
  );

  pwm_capture #(.DATA_WIDTH(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .pwmIn      (pwmIn),
    .measPeriod (p4),
    .measHigh   (h4),
    .measValid  (v4),
    .stuck      (s4),
    .stuckLevel (sl4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic step(input logic v);
    pwmIn = v;
    @(posedge clk);
    #1;
  endtask

  // Drives `cycles` steps of a waveform starting at a rising phase and logs every event by step index.
  task automatic wave(input int period, input int high, input int cycles);
    v_idx.delete(); v_per.delete(); v_high.delete();
    w_per.delete(); w_high.delete(); s_idx.delete();
    for (int i = 0; i < cycles; i++) begin
      step((i % period) < high);
      if (measValid) begin
        v_idx.push_back(i);
        v_per.push_back(int'(measPeriod));
        v_high.push_back(int'(measHigh));
      end
      if (v4) begin
        w_per.push_back(int'(p4));
        w_high.push_back(int'(h4));
      end
      if (stuck) s_idx.push_back(i);
      if (measHigh > measPeriod || h4 > p4) viol++;
    end
  endtask

  initial begin
    rst = 1'b0;
    pwmIn = 1'b0;
    repeat (3) step(1'b0);
    check("rst_period", measPeriod, 0);
    check("rst_high", measHigh, 0);
    check("rst_valid", measValid, 0);
    check("rst_stuck", stuck, 0);
    check("rst_stuck_level", stuckLevel, 0);
    check("rst_period_w4", p4, 0);

    rst = 1'b1;
    repeat (2) step(1'b0);

    // period 2 / high 1: first rise arms, valid 3 edges after each later rise
    wave(2, 1, 20);
    check("p2_count", v_idx.size(), 8);
    check("p2_first_idx", qget(v_idx, 0), 5);
    check("p2_last_idx", qget(v_idx, 7), 19);
    check("p2_period_first", qget(v_per, 0), 2);
    check("p2_high_first", qget(v_high, 0), 1);
    check("p2_period_last", qget(v_per, 7), 2);
    check("p2_high_last", qget(v_high, 7), 1);

    wave(4, 1, 40);
    check("p4_count", v_idx.size(), 11);
    check("p4_boundary_idx", qget(v_idx, 1), 3);
    check("p4_boundary_period", qget(v_per, 1), 2);
    check("p4_first_idx", qget(v_idx, 2), 7);
    check("p4_period", qget(v_per, 2), 4);
    check("p4_high", qget(v_high, 2), 1);
    check("p4_period_last", qget(v_per, 10), 4);
    check("p4_high_last", qget(v_high, 10), 1);

    wave(10, 7, 30);
    check("p10_count", v_idx.size(), 3);
    check("p10_closing_period", qget(v_per, 0), 4);
    check("p10_idx", qget(v_idx, 1), 13);
    check("p10_period", qget(v_per, 1), 10);
    check("p10_high", qget(v_high, 1), 7);
    check("p10_hold_period", measPeriod, 10);
    check("p10_hold_high", measHigh, 7);

    // reset in the middle of a high phase
    wave(10, 7, 5);
    check("pre_rst_period", qget(v_per, 0), 10);
    #2 rst = 1'b0;
    #1;
    check("async_rst_period", measPeriod, 0);
    check("async_rst_high", measHigh, 0);
    check("async_rst_valid", measValid, 0);
    check("async_rst_period_w4", p4, 0);
    repeat (3) step(1'b0);
    rst = 1'b1;
    repeat (3) step(1'b0);
    wave(6, 2, 16);
    check("post_rst_count", v_idx.size(), 2);
    check("post_rst_first_idx", qget(v_idx, 0), 9);
    check("post_rst_period", qget(v_per, 0), 6);
    check("post_rst_high", qget(v_high, 0), 2);
    check("post_rst_period2", qget(v_per, 1), 6);

    // input held high for 1200 cycles
    wave(1300, 1200, 1200);
    check("hold_closing_period", qget(v_per, 0), 4);
    check("hold_closing_high", qget(v_high, 0), 2);
`ifdef PWM_CAPTURE_TIMEOUT_EN
    check("stuck_count", s_idx.size(), 1);
    check("stuck_idx", qget(s_idx, 0), 1003);
    check("stuck_level", stuckLevel, 1);
`else
    check("stuck_count", s_idx.size(), 0);
    check("stuck_level", stuckLevel, 0);
`endif
    repeat (5) step(1'b0);
    wave(10, 3, 12);
`ifdef PWM_CAPTURE_TIMEOUT_EN
    check("after_stuck_count", v_idx.size(), 0);
`else
    check("after_hold_count", v_idx.size(), 1);
    check("after_hold_period", qget(v_per, 0), 1205);
    check("after_hold_high", qget(v_high, 0), 1200);
`endif

    // period 20 / high 5: the 4-bit instance saturates its period
    repeat (5) step(1'b0);
    wave(20, 5, 45);
    check("p20_count", v_idx.size(), 3);
    check("p20_closing_period", qget(v_per, 0), 7);
    check("p20_closing_high", qget(v_high, 0), 2);
    check("p20_period", qget(v_per, 1), 20);
    check("p20_high", qget(v_high, 1), 5);
    check("w4_count", w_per.size(), 3);
    check("w4_closing_period", qget(w_per, 0), 7);
    check("w4_sat_period", qget(w_per, 1), 15);
    check("w4_high", qget(w_high, 1), 5);
    check("w4_sat_period_last", qget(w_per, 2), 15);
    check("high_le_period", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
